// File: rtl/adder_pkg.sv
// Shared opcode encoding and status-flag bit positions for the 4-bit arithmetic tile.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_t;

  localparam int unsigned FLAG_C     = 4;
  localparam int unsigned FLAG_Z     = 5;
  localparam int unsigned FLAG_V     = 6;
  localparam int unsigned FLAG_VALID = 7;

  localparam logic [7:0] OE_MASK = 8'hF0;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the building block for every adder chain in the tile.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_4bit_adder.sv
// Registered 4-bit ALU: ADD/SUB ripple chain, 4x4 array multiplier and 8-bit MAC,
// all built from fa_cell, with a one-cycle output/flag register.
module tt_um_4bit_adder
  import adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] a, b;
  logic       cbit, acc_clr;
  op_t        op;
  logic       unused_bits;

  assign a           = ui_in[3:0];
  assign b           = ui_in[7:4];
  assign op          = op_t'(uio_in[1:0]);
  assign cbit        = uio_in[2];
  assign acc_clr     = uio_in[3];
  assign unused_bits = ^uio_in[7:4];

  // ADD/SUB share one chain: subtraction adds ~B with carry-in ~bin.
  logic       is_sub;
  logic [3:0] b_mod, as_sum;
  logic [4:0] as_c;

  assign is_sub  = (op == OP_SUB);
  assign b_mod   = is_sub ? ~b : b;
  assign as_c[0] = is_sub ? ~cbit : cbit;

  for (genvar i = 0; i < 4; i++) begin : g_addsub
    fa_cell u_fa (
      .a   (a[i]),
      .b   (b_mod[i]),
      .cin (as_c[i]),
      .s   (as_sum[i]),
      .cout(as_c[i+1])
    );
  end

  // Array multiplier: row i adds partial product A&B[i] to the upper bits of row i-1.
  logic [3:0] pp   [4];
  logic [4:0] row  [4];
  logic [4:0] mc   [4];
  logic [7:0] prod;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = a & {4{b[i]}};
  end

  assign row[0] = {1'b0, pp[0]};
  assign mc[0]  = '0;

  for (genvar i = 1; i < 4; i++) begin : g_row
    assign mc[i][0] = 1'b0;
    for (genvar j = 0; j < 4; j++) begin : g_col
      fa_cell u_fa (
        .a   (row[i-1][j+1]),
        .b   (pp[i][j]),
        .cin (mc[i][j]),
        .s   (row[i][j]),
        .cout(mc[i][j+1])
      );
    end
    assign row[i][4] = mc[i][4];
  end

  assign prod = {row[3][4:1], row[3][0], row[2][0], row[1][0], row[0][0]};

  // Accumulate chain: acc + product.
  logic [7:0] acc, acc_sum;
  logic [8:0] ac;

  assign ac[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_mac
    fa_cell u_fa (
      .a   (acc[i]),
      .b   (prod[i]),
      .cin (ac[i]),
      .s   (acc_sum[i]),
      .cout(ac[i+1])
    );
  end

  logic [7:0] next_res;
  logic       next_c, next_v;

  always_comb begin
    next_res = '0;
    next_c   = 1'b0;
    next_v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        next_res = {3'b000, as_c[4], as_sum};
        next_c   = as_c[4];
        next_v   = as_c[3] ^ as_c[4];
      end
      OP_SUB: begin
        next_res = {4'b0000, as_sum};
        next_c   = ~as_c[4];
        next_v   = as_c[3] ^ as_c[4];
      end
      OP_MUL: begin
        next_res = prod;
      end
      OP_MAC: begin
        next_res = acc_sum;
        next_c   = ac[8];
      end
      default: ;
    endcase
  end

  logic c_q, z_q, v_q, valid_q;
  logic [7:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      acc     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= ena;
      if (ena) begin
        if (acc_clr) begin
          res_q <= '0;
          acc   <= '0;
          c_q   <= 1'b0;
          z_q   <= 1'b1;
          v_q   <= 1'b0;
        end else begin
          res_q <= next_res;
          c_q   <= next_c;
          z_q   <= (next_res == 8'h00);
          v_q   <= next_v;
          if (op == OP_MAC) acc <= acc_sum;
        end
      end
    end
  end

  always_comb begin
    uio_out             = '0;
    uio_out[FLAG_C]     = c_q;
    uio_out[FLAG_Z]     = z_q;
    uio_out[FLAG_V]     = v_q;
    uio_out[FLAG_VALID] = valid_q;
  end

  assign uo_out = res_q;
  assign uio_oe = OE_MASK;

endmodule

// File: tb/tb_tt_um_4bit_adder.sv
// Directed-vector bench for tt_um_4bit_adder with hand-computed expectations.
module tb_tt_um_4bit_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int unsigned checks = 0;
  int unsigned failures = 0;

  tt_um_4bit_adder dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Apply one vector, clock it, and settle just after the edge.
  task automatic apply(input logic e, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic cb, input logic clr);
    ena    = e;
    ui_in  = {b, a};
    uio_in = {4'b0000, clr, cb, op};
    @(posedge clk);
    #1;
  endtask

  // Expected uio_out from flag bits {valid, V, Z, C}.
  function automatic logic [7:0] fl(input logic valid, input logic v, input logic z, input logic c);
    return {valid, v, z, c, 4'b0000};
  endfunction

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);

    rst = 1'b0;
    apply(1, 2'b00, 4'd0, 4'd0, 0, 0);
    check("add0_uo", uo_out, 8'h00);
    check("add0_fl", uio_out, fl(1, 0, 1, 0));

    apply(1, 2'b00, 4'd9, 4'd8, 1, 0);
    check("add98_uo", uo_out, 8'h12);
    check("add98_fl", uio_out, fl(1, 1, 0, 1));
    apply(1, 2'b00, 4'd3, 4'd4, 0, 0);
    check("add34_uo", uo_out, 8'h07);
    check("add34_fl", uio_out, fl(1, 0, 0, 0));

    apply(1, 2'b01, 4'd3, 4'd5, 0, 0);
    check("sub35_uo", uo_out, 8'h0E);
    check("sub35_fl", uio_out, fl(1, 0, 0, 1));
    apply(1, 2'b01, 4'd8, 4'd1, 0, 0);
    check("sub81_uo", uo_out, 8'h07);
    check("sub81_fl", uio_out, fl(1, 1, 0, 0));
    apply(1, 2'b01, 4'd4, 4'd3, 1, 0);
    check("sub431_uo", uo_out, 8'h00);
    check("sub431_fl", uio_out, fl(1, 0, 1, 0));

    apply(1, 2'b10, 4'd15, 4'd15, 1, 0);
    check("mulff_uo", uo_out, 8'hE1);
    check("mulff_fl", uio_out, fl(1, 0, 0, 0));
    apply(1, 2'b10, 4'd6, 4'd7, 0, 0);
    check("mul67_uo", uo_out, 8'h2A);

    for (int i = 0; i < 3; i++) begin
      apply(0, 2'(i + 1), 4'(i + 3), 4'(11 - i), 1, 0);
      check("hold_uo", uo_out, 8'h2A);
      check("hold_fl", uio_out, fl(0, 0, 0, 0));
    end

    apply(1, 2'b10, 4'd0, 4'd13, 0, 0);
    check("mul0_uo", uo_out, 8'h00);
    check("mul0_fl", uio_out, fl(1, 0, 1, 0));

    apply(1, 2'b11, 4'd15, 4'd15, 0, 1);
    check("clr_uo", uo_out, 8'h00);
    check("clr_fl", uio_out, fl(1, 0, 1, 0));
    apply(1, 2'b11, 4'd15, 4'd15, 0, 0);
    check("mac1_uo", uo_out, 8'hE1);
    check("mac1_fl", uio_out, fl(1, 0, 0, 0));
    apply(1, 2'b11, 4'd15, 4'd15, 0, 0);
    check("mac2_uo", uo_out, 8'hC2);
    check("mac2_fl", uio_out, fl(1, 0, 0, 1));
    apply(1, 2'b11, 4'd15, 4'd15, 0, 0);
    check("mac3_uo", uo_out, 8'hA3);
    check("mac3_fl", uio_out, fl(1, 0, 0, 1));

    apply(1, 2'b00, 4'd1, 4'd1, 0, 0);
    check("mid_add_uo", uo_out, 8'h02);
    apply(0, 2'b11, 4'd15, 4'd15, 0, 0);
    check("mac_hold_uo", uo_out, 8'h02);
    apply(1, 2'b11, 4'd0, 4'd5, 0, 0);
    check("acc_kept_uo", uo_out, 8'hA3);

    apply(1, 2'b00, 4'd7, 4'd7, 1, 1);
    check("clr2_uo", uo_out, 8'h00);
    check("clr2_fl", uio_out, fl(1, 0, 1, 0));

    apply(1, 2'b11, 4'd15, 4'd15, 0, 0);
    check("mac_pre_uo", uo_out, 8'hE1);
    rst = 1'b1;
    apply(1, 2'b11, 4'd15, 4'd15, 0, 0);
    check("rstmac_uo", uo_out, 8'h00);
    check("rstmac_fl", uio_out, 8'h00);
    rst = 1'b0;
    apply(1, 2'b11, 4'd2, 4'd3, 0, 0);
    check("mac23_uo", uo_out, 8'h06);
    check("mac23_fl", uio_out, fl(1, 0, 0, 0));
    check("oe_end", uio_oe, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
